// File: rtl/marker_locator.sv
// Locates the red, green and blue calibration markers in a raster-ordered pixel
// stream and publishes per-frame bounding boxes, pixel counts and found flags.
module marker_locator #(
  parameter int FRAME_ROWS = 480,
  parameter int FRAME_COLS = 640,
  parameter int HI_TH      = 200,
  parameter int LO_TH      = 50,
  parameter int MIN_PIX    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic [7:0]  pix_R,
  input  logic [7:0]  pix_G,
  input  logic [7:0]  pix_B,
  output logic [51:0] red_box,
  output logic [51:0] green_box,
  output logic [51:0] blue_box,
  output logic [11:0] red_cnt,
  output logic [11:0] green_cnt,
  output logic [11:0] blue_cnt,
  output logic        red_found,
  output logic        green_found,
  output logic        blue_found,
  output logic        all_found,
  output logic        results_valid,
  output logic        frame_err
);

  localparam logic [12:0] LAST_ROW = 13'(FRAME_ROWS - 1);
  localparam logic [12:0] LAST_COL = 13'(FRAME_COLS - 1);
  localparam logic [7:0]  HI       = 8'(HI_TH);
  localparam logic [7:0]  LO       = 8'(LO_TH);
  localparam logic [11:0] MIN_CNT  = 12'(MIN_PIX);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;
  localparam logic [12:0] MIN_INIT = 13'h1FFF;

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

  logic [7:0] chan [3];
  logic [2:0] hit;

  assign chan[0] = pix_R;
  assign chan[1] = pix_G;
  assign chan[2] = pix_B;

  // Colour gi needs its own channel high and both other channels low.
  for (genvar gi = 0; gi < 3; gi++) begin : g_class
    assign hit[gi] = (chan[gi] >= HI) && (chan[(gi + 1) % 3] <= LO) &&
                     (chan[(gi + 2) % 3] <= LO);
  end

  // Stage 1: classified pixel with its coordinates and frame markers.
  logic        s1_valid_reg, s1_sof_reg, s1_eof_reg;
  logic [12:0] s1_row_reg, s1_col_reg;
  logic [2:0]  s1_hit_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_eof_reg   <= 1'b0;
      s1_row_reg   <= '0;
      s1_col_reg   <= '0;
      s1_hit_reg   <= '0;
    end else begin
      s1_valid_reg <= pix_valid;
      s1_sof_reg   <= pix_valid && (row == 13'd0) && (col == 13'd0);
      s1_eof_reg   <= pix_valid && (row == LAST_ROW) && (col == LAST_COL);
      s1_row_reg   <= row;
      s1_col_reg   <= col;
      s1_hit_reg   <= pix_valid ? hit : 3'b000;
    end
  end

  state_t state_reg;
  logic   pub_reg;
  logic   take, fresh, clear;

  // take: accumulate the stage-1 pixel; fresh: start from the init values first.
  always_comb begin
    take = 1'b0;
    if (s1_valid_reg) begin
      case (state_reg)
        ACCUM:         take = 1'b1;
        IDLE, PUBLISH: take = s1_sof_reg;
        default:       take = 1'b0;
      endcase
    end
  end

  assign fresh = take && s1_sof_reg;
  assign clear = (state_reg == PUBLISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pub_reg   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pub_reg   <= 1'b0;
      frame_err <= 1'b0;
      case (state_reg)
        IDLE: if (s1_valid_reg && s1_sof_reg) state_reg <= ACCUM;
        ACCUM: begin
          if (s1_valid_reg && s1_sof_reg) frame_err <= 1'b1;
          else if (s1_valid_reg && s1_eof_reg) state_reg <= PUBLISH;
        end
        PUBLISH: begin
          pub_reg   <= 1'b1;
          // A sof arriving right behind the eof opens the next frame directly.
          state_reg <= (s1_valid_reg && s1_sof_reg) ? ACCUM : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [51:0] snap_box [3];
  logic [11:0] snap_cnt [3];
  logic [2:0]  snap_found;

  for (genvar gi = 0; gi < 3; gi++) begin : g_colour
    logic [12:0] min_row_reg, min_col_reg, max_row_reg, max_col_reg;
    logic [11:0] cnt_reg;
    logic [12:0] base_min_row, base_min_col, base_max_row, base_max_col;
    logic [11:0] base_cnt;
    logic [51:0] snap_box_reg;
    logic [11:0] snap_cnt_reg;

    always_comb begin
      base_min_row = min_row_reg;
      base_min_col = min_col_reg;
      base_max_row = max_row_reg;
      base_max_col = max_col_reg;
      base_cnt     = cnt_reg;
      if (fresh || clear) begin
        base_min_row = MIN_INIT;
        base_min_col = MIN_INIT;
        base_max_row = '0;
        base_max_col = '0;
        base_cnt     = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        min_row_reg  <= MIN_INIT;
        min_col_reg  <= MIN_INIT;
        max_row_reg  <= '0;
        max_col_reg  <= '0;
        cnt_reg      <= '0;
        snap_box_reg <= '0;
        snap_cnt_reg <= '0;
      end else begin
        if (take && s1_hit_reg[gi]) begin
          cnt_reg     <= (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 12'd1;
          min_row_reg <= (s1_row_reg < base_min_row) ? s1_row_reg : base_min_row;
          min_col_reg <= (s1_col_reg < base_min_col) ? s1_col_reg : base_min_col;
          max_row_reg <= (s1_row_reg > base_max_row) ? s1_row_reg : base_max_row;
          max_col_reg <= (s1_col_reg > base_max_col) ? s1_col_reg : base_max_col;
        end else begin
          cnt_reg     <= base_cnt;
          min_row_reg <= base_min_row;
          min_col_reg <= base_min_col;
          max_row_reg <= base_max_row;
          max_col_reg <= base_max_col;
        end
        // Snapshot holds the finished frame for one cycle so all results land together.
        if (clear) begin
          snap_box_reg <= {min_row_reg, min_col_reg, max_row_reg, max_col_reg};
          snap_cnt_reg <= cnt_reg;
        end
      end
    end

    assign snap_box[gi]   = snap_box_reg;
    assign snap_cnt[gi]   = snap_cnt_reg;
    assign snap_found[gi] = (snap_cnt_reg >= MIN_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_box       <= '0;
      green_box     <= '0;
      blue_box      <= '0;
      red_cnt       <= '0;
      green_cnt     <= '0;
      blue_cnt      <= '0;
      red_found     <= 1'b0;
      green_found   <= 1'b0;
      blue_found    <= 1'b0;
      all_found     <= 1'b0;
      results_valid <= 1'b0;
    end else begin
      results_valid <= pub_reg;
      if (pub_reg) begin
        red_box     <= snap_box[0];
        green_box   <= snap_box[1];
        blue_box    <= snap_box[2];
        red_cnt     <= snap_cnt[0];
        green_cnt   <= snap_cnt[1];
        blue_cnt    <= snap_cnt[2];
        red_found   <= snap_found[0];
        green_found <= snap_found[1];
        blue_found  <= snap_found[2];
        all_found   <= &snap_found;
      end
    end
  end

endmodule

// File: doc/marker_locator.md
Name: marker_locator

Overview:
- Consumes the camera/VGA pixel stream and detects the three calibration markers (red, green, blue) that the overlay stage stamps into the frame.
- Per frame, reports each marker's bounding box, pixel count and found flag.
- Results are registered once per frame, with a one-cycle results_valid pulse.
- Sits downstream of frame capture. Feeds paddle/ball geometry calibration.

Parameters:
- FRAME_ROWS, 480, rows per frame; last row index is FRAME_ROWS-1
- FRAME_COLS, 640, columns per frame; last column index is FRAME_COLS-1
- HI_TH, 200, a channel is "on" when its value is >= HI_TH
- LO_TH, 50, a channel is "off" when its value is <= LO_TH (LO_TH < HI_TH is required)
- MIN_PIX, 4, minimum pixel count for a marker to be declared found

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  row/col/R/G/B are valid this cycle
- row  in  13  pixel row
- col  in  13  pixel column
- pix_R  in  8  red channel
- pix_G  in  8  green channel
- pix_B  in  8  blue channel
- red_box  out  52  {min_row, min_col, max_row, max_col} of the red marker
- green_box  out  52  same layout, green marker
- blue_box  out  52  same layout, blue marker
- red_cnt, green_cnt, blue_cnt  out  12 each  saturating pixel counts
- red_found, green_found, blue_found  out  1 each  count >= MIN_PIX
- all_found  out  1  AND of the three found flags
- results_valid  out  1  one-cycle pulse when all result outputs update
- frame_err  out  1  one-cycle pulse on a truncated frame

Behaviour:
- Reset (synchronous, active-high): all outputs 0, accumulators cleared, FSM enters IDLE. A reset asserted mid-frame discards that frame; no results_valid follows.
- Classification (stage 1, registered): applies to pixels with pix_valid=1.
  - red = R>=HI_TH && G<=LO_TH && B<=LO_TH; green and blue are analogous.
  - At most one class per pixel. Registered alongside row/col, a valid bit, and sof/eof flags.
  - sof = (row==0 && col==0). eof = (row==FRAME_ROWS-1 && col==FRAME_COLS-1).
- Accumulation (stage 2): for each colour hit:
  - count+1, saturating at 4095.
  - min_row/min_col = min(current, pixel); max_row/max_col = max(current, pixel).
  - Accumulator init values: min fields 13'h1FFF, max fields 0, count 0.
- FSM:
  - IDLE: ignores pixels until a stage-1 sof. The sof pixel is then accumulated from the init state -> ACCUM.
  - ACCUM:
    - Accumulates each valid stage-1 pixel.
    - On eof: accumulates that pixel -> PUBLISH.
    - On sof before eof (truncated frame): pulse frame_err, re-init accumulators, accumulate the sof pixel, stay in ACCUM.
  - PUBLISH (one cycle):
    - Copy accumulators to the box/cnt outputs.
    - Compute found flags and all_found.
    - Pulse results_valid; clear accumulators -> IDLE.
- Latency: eof pixel sampled at edge N -> outputs updated and results_valid=1 after edge N+3, for exactly one cycle.
- Hold behaviour:
  - Outputs hold their values between publishes.
  - pix_valid=0 gaps stall nothing; the FSM simply holds.
- Colour with zero hits: count=0, found=0, box = {1FFF,1FFF,0,0} (an empty box is reported as-is).
- Simultaneous eof and sof is only possible when FRAME_ROWS=FRAME_COLS=1. This is unsupported; parameters must be >=2.
- Out-of-range row/col still classify and accumulate; only the exact eof coordinate ends a frame.

Test Plan:
- Standard 640x480 frame, grey background 128:
  - Red 255/0/0 at rows 0-4, cols 0-4; green at rows 0-4, cols 621-624; blue at rows 474-477, cols 0-4.
  - Expect red_box={0,0,4,4}, red_cnt=25; green_box={0,621,4,624}, green_cnt=20; blue_box={474,0,477,4}, blue_cnt=20.
  - Expect all_found=1 and a single results_valid pulse 3 cycles after the eof pixel.
- Frame with the blue marker replaced by (255,255,255) -> blue_cnt=0, blue_found=0, blue_box={1FFF,1FFF,0,0}, all_found=0; red and green unchanged.
- Frame with a green marker of only 3 pixels (MIN_PIX=4) -> green_cnt=3, green_found=0.
- Truncation:
  - Frame stopped at row 200, then a new frame started at row 0 col 0.
  - Expect a frame_err pulse and no results_valid for the truncated frame.
  - The next complete frame reports only its own markers.
- Reset asserted for 1 cycle at row 300 -> all outputs 0. The following full frame produces correct results. No stale results_valid.
- Random pix_valid gaps (~30% low) over the standard frame -> results identical to the first test.
